// File: rtl/eth_pkg.sv
// Shared Ethernet receive/transmit constants, CRC parameters and ARP parser state type.
package eth_pkg;

    localparam logic [15:0] ETHTYPE_ARP   = 16'h0806;
    localparam logic [15:0] ETHTYPE_IPV4  = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OP_REP    = 16'h0002;
    localparam logic [7:0]  ARP_HLEN_ETH  = 8'h06;
    localparam logic [7:0]  ARP_PLEN_IPV4 = 8'h04;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int          ETH_MIN_FRAME = 64;

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        HUNT     = 2'd1,
        PREAMBLE = 2'd2,
        BODY     = 2'd3
    } arp_rx_state_t;

endpackage

// File: rtl/eth_crc32_byte.sv
// One-byte step of the reflected CRC-32 (LSB-first), no final inversion.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    // Eight unrolled shift/xor steps of the reflected polynomial
    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {24'h0, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_arp_rx.sv
// Receive-side ARP parser: strips preamble, checks FCS and header, reports sender MAC/IP.
//
// state    | meaning
// WAIT_GAP | ignore bytes until rx_data_vl drops (after reset or a bad preamble)
// HUNT     | idle in the gap, waiting for the first preamble byte
// PREAMBLE | inside 0x55 run, waiting for SFD
// BODY     | frame bytes: CRC, byte index, field checks; evaluation on rx_data_vl fall
module eth_arp_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A8_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_vl,
    output logic        arp_vld,
    output logic        arp_is_reply,
    output logic [47:0] arp_sha,
    output logic [31:0] arp_spa,
    output logic [15:0] crc_err_cnt
);

    arp_rx_state_t state_q, state_d;
    logic [10:0]   idx_q, idx_d;
    logic [31:0]   crc_q, crc_d, crc_next;
    logic          hdr_ok_q, hdr_ok_d;
    logic          dst_local_q, dst_local_d;
    logic          dst_bcast_q, dst_bcast_d;
    logic [47:0]   sha_sh_q, sha_sh_d;
    logic [31:0]   spa_sh_q, spa_sh_d;
    logic          rep_sh_q, rep_sh_d;
    logic          vld_q, vld_d;
    logic          is_reply_q, is_reply_d;
    logic [47:0]   sha_q, sha_d;
    logic [31:0]   spa_q, spa_d;
    logic [15:0]   err_cnt_q, err_cnt_d;

    logic [7:0]    mac_byte;
    logic          field_ok;
    logic          crc_ok, len_ok;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data_in (rx_data),
        .crc_out (crc_next)
    );

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_GAP;
            idx_q       <= '0;
            crc_q       <= '0;
            hdr_ok_q    <= 1'b0;
            dst_local_q <= 1'b0;
            dst_bcast_q <= 1'b0;
            sha_sh_q    <= '0;
            spa_sh_q    <= '0;
            rep_sh_q    <= 1'b0;
            vld_q       <= 1'b0;
            is_reply_q  <= 1'b0;
            sha_q       <= '0;
            spa_q       <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            crc_q       <= crc_d;
            hdr_ok_q    <= hdr_ok_d;
            dst_local_q <= dst_local_d;
            dst_bcast_q <= dst_bcast_d;
            sha_sh_q    <= sha_sh_d;
            spa_sh_q    <= spa_sh_d;
            rep_sh_q    <= rep_sh_d;
            vld_q       <= vld_d;
            is_reply_q  <= is_reply_d;
            sha_q       <= sha_d;
            spa_q       <= spa_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_GAP: if (!rx_data_vl) state_d = HUNT;
            HUNT:     if (rx_data_vl) state_d = (rx_data == PREAMBLE_BYTE) ? PREAMBLE : WAIT_GAP;
            PREAMBLE: begin
                if (!rx_data_vl)                   state_d = HUNT;
                else if (rx_data == SFD_BYTE)      state_d = BODY;
                else if (rx_data != PREAMBLE_BYTE) state_d = WAIT_GAP;
            end
            BODY:     if (!rx_data_vl) state_d = HUNT;
            default:  state_d = WAIT_GAP;
        endcase
    end

    // Expected value of the current byte for the fixed header positions
    always_comb begin
        mac_byte = 8'h00;
        field_ok = 1'b1;
        case (idx_q)
            11'd0:  mac_byte = LOCAL_MAC[47:40];
            11'd1:  mac_byte = LOCAL_MAC[39:32];
            11'd2:  mac_byte = LOCAL_MAC[31:24];
            11'd3:  mac_byte = LOCAL_MAC[23:16];
            11'd4:  mac_byte = LOCAL_MAC[15:8];
            11'd5:  mac_byte = LOCAL_MAC[7:0];
            11'd12: field_ok = (rx_data == ETHTYPE_ARP[15:8]);
            11'd13: field_ok = (rx_data == ETHTYPE_ARP[7:0]);
            11'd14: field_ok = (rx_data == ARP_HTYPE_ETH[15:8]);
            11'd15: field_ok = (rx_data == ARP_HTYPE_ETH[7:0]);
            11'd16: field_ok = (rx_data == ETHTYPE_IPV4[15:8]);
            11'd17: field_ok = (rx_data == ETHTYPE_IPV4[7:0]);
            11'd18: field_ok = (rx_data == ARP_HLEN_ETH);
            11'd19: field_ok = (rx_data == ARP_PLEN_IPV4);
            11'd20: field_ok = (rx_data == ARP_OP_REQ[15:8]);
            11'd21: field_ok = (rx_data == ARP_OP_REQ[7:0]) || (rx_data == ARP_OP_REP[7:0]);
            11'd38: field_ok = (rx_data == LOCAL_IP[31:24]);
            11'd39: field_ok = (rx_data == LOCAL_IP[23:16]);
            11'd40: field_ok = (rx_data == LOCAL_IP[15:8]);
            11'd41: field_ok = (rx_data == LOCAL_IP[7:0]);
            default: field_ok = 1'b1;
        endcase
    end

    assign crc_ok = (crc_q == CRC32_RESIDUE);
    assign len_ok = (idx_q >= 11'(ETH_MIN_FRAME));

    // Body processing, shadow capture and end-of-frame evaluation
    always_comb begin
        idx_d       = idx_q;
        crc_d       = crc_q;
        hdr_ok_d    = hdr_ok_q;
        dst_local_d = dst_local_q;
        dst_bcast_d = dst_bcast_q;
        sha_sh_d    = sha_sh_q;
        spa_sh_d    = spa_sh_q;
        rep_sh_d    = rep_sh_q;
        vld_d       = 1'b0;
        is_reply_d  = is_reply_q;
        sha_d       = sha_q;
        spa_d       = spa_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            PREAMBLE: begin
                if (rx_data_vl && rx_data == SFD_BYTE) begin
                    idx_d       = '0;
                    crc_d       = CRC32_INIT;
                    hdr_ok_d    = 1'b1;
                    dst_local_d = 1'b1;
                    dst_bcast_d = 1'b1;
                end
            end
            BODY: begin
                if (rx_data_vl) begin
                    crc_d = crc_next;
                    if (idx_q != 11'h7FF) idx_d = idx_q + 11'd1;
                    if (!field_ok) hdr_ok_d = 1'b0;
                    if (idx_q < 11'd6) begin
                        dst_local_d = dst_local_q && (rx_data == mac_byte);
                        dst_bcast_d = dst_bcast_q && (rx_data == 8'hFF);
                    end
                    // Destination decided once its last byte has been seen
                    if (idx_q == 11'd5 && !dst_local_d && !dst_bcast_d) hdr_ok_d = 1'b0;
                    if (idx_q >= 11'd22 && idx_q <= 11'd27) sha_sh_d = {sha_sh_q[39:0], rx_data};
                    if (idx_q >= 11'd28 && idx_q <= 11'd31) spa_sh_d = {spa_sh_q[23:0], rx_data};
                    if (idx_q == 11'd21) rep_sh_d = (rx_data == ARP_OP_REP[7:0]);
                end else begin
                    if (hdr_ok_q && crc_ok && len_ok) begin
                        vld_d      = 1'b1;
                        is_reply_d = rep_sh_q;
                        sha_d      = sha_sh_q;
                        spa_d      = spa_sh_q;
                    end
                    // Runts are never counted as FCS errors
                    if (len_ok && !crc_ok && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    assign arp_vld      = vld_q;
    assign arp_is_reply = is_reply_q;
    assign arp_sha      = sha_q;
    assign arp_spa      = spa_q;
    assign crc_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_eth_arp_rx.sv
// Directed testbench for eth_arp_rx: builds ARP/IPv4 frames with computed FCS and checks reports.
module tb_eth_arp_rx;

    typedef logic [7:0] bytes_t [$];

    localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MAC_LOCAL = 48'h02_00_00_00_00_01;
    localparam logic [47:0] MAC_OTHER = 48'h02_00_00_00_00_02;
    localparam logic [31:0] IP_LOCAL  = 32'hC0A8_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_vl = 1'b0;
    logic        arp_vld;
    logic        arp_is_reply;
    logic [47:0] arp_sha;
    logic [31:0] arp_spa;
    logic [15:0] crc_err_cnt;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    eth_arp_rx dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_data_vl   (rx_data_vl),
        .arp_vld      (arp_vld),
        .arp_is_reply (arp_is_reply),
        .arp_sha      (arp_sha),
        .arp_spa      (arp_spa),
        .crc_err_cnt  (crc_err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (arp_vld === 1'b1) pulse_cnt <= pulse_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] calc_fcs(input bytes_t f);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (f[i]) begin
            c = c ^ {24'h0, f[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bytes_t add_fcs(input bytes_t f);
        bytes_t g;
        logic [31:0] fcs;
        g = f;
        fcs = calc_fcs(f);
        for (int i = 0; i < 4; i++) g.push_back(fcs[8*i +: 8]);
        return g;
    endfunction

    function automatic bytes_t build_body(input logic [47:0] dst, input logic [15:0] etype,
                                          input logic [15:0] oper, input logic [47:0] sha,
                                          input logic [31:0] spa, input logic [31:0] tpa);
        bytes_t f;
        for (int i = 5; i >= 0; i--) f.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) f.push_back(sha[8*i +: 8]);
        f.push_back(etype[15:8]); f.push_back(etype[7:0]);
        f.push_back(8'h00); f.push_back(8'h01);
        f.push_back(8'h08); f.push_back(8'h00);
        f.push_back(8'h06); f.push_back(8'h04);
        f.push_back(oper[15:8]); f.push_back(oper[7:0]);
        for (int i = 5; i >= 0; i--) f.push_back(sha[8*i +: 8]);
        for (int i = 3; i >= 0; i--) f.push_back(spa[8*i +: 8]);
        for (int i = 0; i < 6; i++) f.push_back(8'h00);
        for (int i = 3; i >= 0; i--) f.push_back(tpa[8*i +: 8]);
        while (f.size() < 60) f.push_back(8'h00);
        return f;
    endfunction

    // Drives preamble+SFD+frame starting at a negedge, then gap cycles of rx_data_vl=0.
    // vld_n1 is arp_vld sampled in cycle N+1.
    task automatic send_frame(input bytes_t f, input int gap, input int rst_at, output logic vld_n1);
        for (int i = 0; i < 7; i++) begin
            rx_data_vl = 1'b1; rx_data = 8'h55; rst = 1'b0;
            @(negedge clk);
        end
        rx_data = 8'hD5;
        @(negedge clk);
        foreach (f[i]) begin
            rx_data = f[i];
            rst = (i == rst_at);
            @(negedge clk);
        end
        rst = 1'b0; rx_data_vl = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        vld_n1 = arp_vld;
        for (int i = 1; i < gap; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_data_vl = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (arp_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", arp_vld); end
        checks++; if (arp_is_reply !== 1'b0) begin errors++; $display("FAIL reset_is_reply: got %b want 0", arp_is_reply); end
        checks++; if (arp_sha !== 48'h0) begin errors++; $display("FAIL reset_sha: got %h want 0", arp_sha); end
        checks++; if (arp_spa !== 32'h0) begin errors++; $display("FAIL reset_spa: got %h want 0", arp_spa); end
        checks++; if (crc_err_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", crc_err_cnt); end
    endtask

    task automatic test_bcast_request();
        bytes_t f; logic v; int p0;
        f = add_fcs(build_body(MAC_BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_000A, IP_LOCAL));
        p0 = pulse_cnt;
        send_frame(f, 4, -1, v);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL bcast_vld_n1: got %b want 1", v); end
        checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL bcast_pulses: got %0d want 1", pulse_cnt - p0); end
        checks++; if (arp_is_reply !== 1'b0) begin errors++; $display("FAIL bcast_is_reply: got %b want 0", arp_is_reply); end
        checks++; if (arp_sha !== 48'h0011_2233_4455) begin errors++; $display("FAIL bcast_sha: got %h want 001122334455", arp_sha); end
        checks++; if (arp_spa !== 32'hC0A8_000A) begin errors++; $display("FAIL bcast_spa: got %h want c0a8000a", arp_spa); end
    endtask

    task automatic test_bad_fcs();
        bytes_t f; logic v; int p0;
        f = add_fcs(build_body(MAC_BCAST, 16'h0806, 16'h0001, 48'h0A0B_0C0D_0E0F, 32'hC0A8_0063, IP_LOCAL));
        f[f.size()-1] = f[f.size()-1] ^ 8'h10;
        p0 = pulse_cnt;
        send_frame(f, 4, -1, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL badfcs_vld: got %b want 0", v); end
        checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL badfcs_pulses: got %0d want 0", pulse_cnt - p0); end
        checks++; if (crc_err_cnt !== 16'd1) begin errors++; $display("FAIL badfcs_cnt: got %0d want 1", crc_err_cnt); end
        checks++; if (arp_sha !== 48'h0011_2233_4455) begin errors++; $display("FAIL badfcs_sha_held: got %h want 001122334455", arp_sha); end
        checks++; if (arp_spa !== 32'hC0A8_000A) begin errors++; $display("FAIL badfcs_spa_held: got %h want c0a8000a", arp_spa); end
    endtask

    task automatic test_unicast_reply();
        bytes_t f; logic v; int p0;
        f = add_fcs(build_body(MAC_LOCAL, 16'h0806, 16'h0002, 48'h6677_8899_AABB, 32'hC0A8_0014, IP_LOCAL));
        send_frame(f, 4, -1, v);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL reply_vld: got %b want 1", v); end
        checks++; if (arp_is_reply !== 1'b1) begin errors++; $display("FAIL reply_is_reply: got %b want 1", arp_is_reply); end
        checks++; if (arp_sha !== 48'h6677_8899_AABB) begin errors++; $display("FAIL reply_sha: got %h want 66778899aabb", arp_sha); end
        checks++; if (arp_spa !== 32'hC0A8_0014) begin errors++; $display("FAIL reply_spa: got %h want c0a80014", arp_spa); end
        p0 = pulse_cnt;
        f = add_fcs(build_body(MAC_LOCAL, 16'h0806, 16'h0002, 48'h1111_2222_3333, 32'hC0A8_0015, 32'hC0A8_0002));
        send_frame(f, 4, -1, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL wrong_tpa_vld: got %b want 0", v); end
        f = add_fcs(build_body(MAC_OTHER, 16'h0806, 16'h0002, 48'h1111_2222_3333, 32'hC0A8_0015, IP_LOCAL));
        send_frame(f, 4, -1, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL wrong_dst_vld: got %b want 0", v); end
        checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL filtered_pulses: got %0d want 0", pulse_cnt - p0); end
        checks++; if (crc_err_cnt !== 16'd1) begin errors++; $display("FAIL filtered_cnt: got %0d want 1", crc_err_cnt); end
        checks++; if (arp_sha !== 48'h6677_8899_AABB) begin errors++; $display("FAIL filtered_sha_held: got %h want 66778899aabb", arp_sha); end
    endtask

    task automatic test_ipv4_and_runt();
        bytes_t f, r; logic v; int p0;
        p0 = pulse_cnt;
        f = add_fcs(build_body(MAC_BCAST, 16'h0800, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0030, IP_LOCAL));
        send_frame(f, 4, -1, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL ipv4_vld: got %b want 0", v); end
        f = build_body(MAC_BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0031, IP_LOCAL);
        for (int i = 0; i < 36; i++) r.push_back(f[i]);
        r = add_fcs(r);
        r[r.size()-1] = r[r.size()-1] ^ 8'h01;
        send_frame(r, 4, -1, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL runt_vld: got %b want 0", v); end
        checks++; if (crc_err_cnt !== 16'd1) begin errors++; $display("FAIL runt_cnt: got %0d want 1", crc_err_cnt); end
        checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL ipv4_runt_pulses: got %0d want 0", pulse_cnt - p0); end
    endtask

    task automatic test_back_to_back();
        bytes_t f1, f2; logic v1, v2; int p0;
        f1 = add_fcs(build_body(MAC_BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0020, IP_LOCAL));
        f2 = add_fcs(build_body(MAC_BCAST, 16'h0806, 16'h0001, 48'h0011_2233_4455, 32'hC0A8_0021, IP_LOCAL));
        p0 = pulse_cnt;
        send_frame(f1, 1, -1, v1);
        send_frame(f2, 4, -1, v2);
        checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL b2b_first_vld: got %b want 1", v1); end
        checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL b2b_second_vld: got %b want 1", v2); end
        checks++; if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - p0); end
        checks++; if (arp_spa !== 32'hC0A8_0021) begin errors++; $display("FAIL b2b_spa: got %h want c0a80021", arp_spa); end
        checks++; if (arp_is_reply !== 1'b0) begin errors++; $display("FAIL b2b_is_reply: got %b want 0", arp_is_reply); end
    endtask

    task automatic test_reset_mid_frame();
        bytes_t f; logic v; int p0;
        f = add_fcs(build_body(MAC_BCAST, 16'h0806, 16'h0002, 48'hDEAD_BEEF_0001, 32'hC0A8_0040, IP_LOCAL));
        p0 = pulse_cnt;
        send_frame(f, 4, 25, v);
        checks++; if (v !== 1'b0) begin errors++; $display("FAIL midrst_vld: got %b want 0", v); end
        checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL midrst_pulses: got %0d want 0", pulse_cnt - p0); end
        checks++; if (arp_sha !== 48'h0) begin errors++; $display("FAIL midrst_sha: got %h want 0", arp_sha); end
        checks++; if (crc_err_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt: got %0d want 0", crc_err_cnt); end
        f = add_fcs(build_body(MAC_BCAST, 16'h0806, 16'h0002, 48'hDEAD_BEEF_0002, 32'hC0A8_0041, IP_LOCAL));
        send_frame(f, 4, -1, v);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL after_rst_vld: got %b want 1", v); end
        checks++; if (arp_sha !== 48'hDEAD_BEEF_0002) begin errors++; $display("FAIL after_rst_sha: got %h want deadbeef0002", arp_sha); end
        checks++; if (arp_spa !== 32'hC0A8_0041) begin errors++; $display("FAIL after_rst_spa: got %h want c0a80041", arp_spa); end
        checks++; if (arp_is_reply !== 1'b1) begin errors++; $display("FAIL after_rst_is_reply: got %b want 1", arp_is_reply); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_bcast_request();
        test_bad_fcs();
        test_unicast_reply();
        test_ipv4_and_runt();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
